// File: rtl/noc_pkg.sv
// Shared flit protocol definitions for the core-to-router link.
// The DISCARD state exists only when DEPKT_ADDR_CHECK_EN is defined.
package noc_pkg;

    localparam int FLIT_W       = 16;
    localparam int ADDR_W       = 4;
    localparam int SLICE_W      = 14;
    localparam int HEAD_SLICE_W = 6;

    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_RSVD = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TYPE = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        HOLD = 2'd2
`ifdef DEPKT_ADDR_CHECK_EN
        , DISCARD = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/flit_depacketizer_if.sv
// Flit input stream and packet output handshake of the depacketizer.
// slave: depacketizer side; master: producer/consumer side.
interface flit_depacketizer_if
    import noc_pkg::*;
#(
    parameter int N = 4
);
    localparam int PAYLOAD_W = SLICE_W * N - 8;

    logic [FLIT_W-1:0]    flit_in;
    logic                 flit_valid;
    logic                 flit_ready;
    logic                 pkt_valid;
    logic                 pkt_ready;
    logic [ADDR_W-1:0]    pkt_src;
    logic [ADDR_W-1:0]    pkt_des;
    logic [PAYLOAD_W-1:0] pkt_data;
    logic                 err;
    logic [1:0]           err_code;

    modport slave (
        input  flit_in, flit_valid, pkt_ready,
        output flit_ready, pkt_valid, pkt_src, pkt_des, pkt_data, err, err_code
    );

    modport master (
        output flit_in, flit_valid, pkt_ready,
        input  flit_ready, pkt_valid, pkt_src, pkt_des, pkt_data, err, err_code
    );

endinterface

// File: rtl/flit_depacketizer.sv
// Reassembles head/body/tail flit streams into one packet held until consumed.
// Optional DEPKT_ADDR_CHECK_EN drops packets whose destination is not MY_ADDR.
module flit_depacketizer
    import noc_pkg::*;
#(
    parameter int                N       = 4,
    parameter logic [ADDR_W-1:0] MY_ADDR = 4'h0
) (
    input logic                clk,
    input logic                rst,
    flit_depacketizer_if.slave bus
);
    localparam int PAYLOAD_W = SLICE_W * N - 8;
    localparam int CNT_W     = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t               r_state, w_state_nxt, w_head_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_flit_ready, r_pkt_valid, r_err, w_err_nxt;
    logic [1:0]           r_err_code, w_err_code_nxt;
    logic [ADDR_W-1:0]    r_src, r_des;
    logic [PAYLOAD_W-1:0] r_data;
    logic [1:0]           w_type;
    logic [ADDR_W-1:0]    w_flit_src, w_flit_des;
    logic                 w_fire, w_head, w_store, w_addr_err;

    assign w_type     = bus.flit_in[FLIT_W-1 -: 2];
    assign w_flit_src = bus.flit_in[13:10];
    assign w_flit_des = bus.flit_in[9:6];
    assign w_fire     = bus.flit_valid && r_flit_ready;

`ifdef DEPKT_ADDR_CHECK_EN
    assign w_addr_err   = (w_flit_des != MY_ADDR);
    assign w_head_state = w_addr_err ? DISCARD : BODY;
`else
    logic w_unused_my_addr;
    assign w_unused_my_addr = ^MY_ADDR;
    assign w_addr_err       = 1'b0;
    assign w_head_state     = BODY;
`endif

    // Next-state, counter and error decode for one accepted flit.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = ERR_NONE;
        w_head         = 1'b0;
        w_store        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if (w_type == FT_HEAD) begin
                        w_head         = 1'b1;
                        w_cnt_nxt      = CNT_ONE;
                        w_state_nxt    = w_head_state;
                        w_err_nxt      = w_addr_err;
                        w_err_code_nxt = w_addr_err ? ERR_ADDR : ERR_NONE;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_TYPE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BODY: begin
                if (w_fire) begin
                    case (w_type)
                        FT_BODY: begin
                            if (r_cnt == CNT_LAST) begin
                                w_err_nxt      = 1'b1;
                                w_err_code_nxt = ERR_LEN;
                                w_state_nxt    = IDLE;
                            end else begin
                                w_store   = 1'b1;
                                w_cnt_nxt = r_cnt + CNT_ONE;
                            end
                        end
                        FT_TAIL: begin
                            if (r_cnt == CNT_LAST) begin
                                w_store     = 1'b1;
                                w_state_nxt = HOLD;
                            end else begin
                                w_err_nxt      = 1'b1;
                                w_err_code_nxt = ERR_LEN;
                                w_state_nxt    = IDLE;
                            end
                        end
                        // A new head restarts reassembly; the length error wins.
                        FT_HEAD: begin
                            w_head         = 1'b1;
                            w_cnt_nxt      = CNT_ONE;
                            w_state_nxt    = w_head_state;
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_LEN;
                        end
                        default: begin
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_TYPE;
                            w_state_nxt    = IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = BODY;
                end
            end
            HOLD: begin
                if (bus.pkt_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
`ifdef DEPKT_ADDR_CHECK_EN
            DISCARD: begin
                if (w_fire && (w_type == FT_TAIL)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DISCARD;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state, handshake flags and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_flit_ready <= 1'b1;
            r_pkt_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_flit_ready <= (w_state_nxt != HOLD);
            r_pkt_valid  <= (w_state_nxt == HOLD);
            r_err        <= w_err_nxt;
            r_err_code   <= w_err_code_nxt;
        end
    end

    // Header fields and payload slices, written in place by slice index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_des  <= '0;
            r_data <= '0;
        end else begin
            if (w_head) begin
                r_src <= w_flit_src;
                r_des <= w_flit_des;
                r_data[PAYLOAD_W-1 -: HEAD_SLICE_W] <= bus.flit_in[HEAD_SLICE_W-1:0];
            end else if (w_store) begin
                r_data[SLICE_W*(N-1-int'(r_cnt)) +: SLICE_W] <= bus.flit_in[SLICE_W-1:0];
            end else begin
                r_data <= r_data;
            end
        end
    end

    assign bus.flit_ready = r_flit_ready;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.pkt_src    = r_src;
    assign bus.pkt_des    = r_des;
    assign bus.pkt_data   = r_data;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;

endmodule

// File: tb/tb_flit_depacketizer.sv
// Scoreboard bench for flit_depacketizer with N=4: directed flit streams,
// expected packets/errors queued at issue time, a monitor checks outputs.
module tb_flit_depacketizer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  des;
        logic [47:0] data;
    } pkt_t;

    pkt_t       exp_pkt_q[$];
    logic [1:0] exp_err_q[$];

    localparam pkt_t P1 = '{src: 4'h3, des: 4'hA, data: 48'h0123456789AB};
    localparam pkt_t P2 = '{src: 4'h5, des: 4'h2, data: 48'hFEDCBA987654};

    flit_depacketizer_if #(.N(4)) bus ();

    flit_depacketizer #(.N(4), .MY_ADDR(4'hA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] f);
        int budget = 20;
        bus.flit_in    = f;
        bus.flit_valid = 1'b1;
        while (!bus.flit_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.flit_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout flit=%h flit_ready=%b required=1", f, bus.flit_ready);
        end
        @(negedge clk);
        bus.flit_valid = 1'b0;
    endtask

    task automatic send_p1();
        send(16'h0E80); send(16'h5234); send(16'h559E); send(16'h89AB);
    endtask

    task automatic send_p2();
        send(16'h14BF); send(16'h6DCB); send(16'h6A61); send(16'hB654);
    endtask

    // Monitor: sample just after the falling edge, once inputs have settled.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus.pkt_valid && bus.pkt_ready) begin
                if (exp_pkt_q.size() == 0) begin
                    chk("unexpected_pkt", {bus.pkt_src, bus.pkt_des, bus.pkt_data}, 64'h0);
                end else begin
                    pkt_t e;
                    e = exp_pkt_q.pop_front();
                    chk("pkt_src",  {60'h0, bus.pkt_src},  {60'h0, e.src});
                    chk("pkt_des",  {60'h0, bus.pkt_des},  {60'h0, e.des});
                    chk("pkt_data", {16'h0, bus.pkt_data}, {16'h0, e.data});
                end
            end
            if (bus.err) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_err", {62'h0, bus.err_code}, 64'h0);
                end else begin
                    chk("err_code", {62'h0, bus.err_code}, {62'h0, exp_err_q.pop_front()});
                end
            end
        end
    end

    initial begin
        bus.flit_in    = 16'h0000;
        bus.flit_valid = 1'b0;
        bus.pkt_ready  = 1'b1;
        #1;
        chk("rst_pkt_valid", {63'h0, bus.pkt_valid}, 64'h0);
        chk("rst_outputs", {bus.pkt_src, bus.pkt_des, bus.pkt_data}, 64'h0);
        chk("rst_err", {61'h0, bus.err, bus.err_code}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_flit_ready", {63'h0, bus.flit_ready}, 64'h1);

        // Back-to-back packet, consumer always ready.
        exp_pkt_q.push_back(P1);
        send_p1();
        chk("latency_pkt_valid", {63'h0, bus.pkt_valid}, 64'h1);
        @(negedge clk);
        chk("released_pkt_valid", {63'h0, bus.pkt_valid}, 64'h0);

        // Consumer stalls for five cycles.
        bus.pkt_ready = 1'b0;
        exp_pkt_q.push_back(P1);
        send_p1();
        for (int i = 0; i < 5; i++) begin
            chk("hold_pkt_valid", {63'h0, bus.pkt_valid}, 64'h1);
            chk("hold_flit_ready", {63'h0, bus.flit_ready}, 64'h0);
            chk("hold_pkt_data", {16'h0, bus.pkt_data}, {16'h0, P1.data});
            @(negedge clk);
        end
        bus.pkt_ready = 1'b1;
        @(negedge clk);
        chk("after_hold_pkt_valid", {63'h0, bus.pkt_valid}, 64'h0);
        chk("after_hold_flit_ready", {63'h0, bus.flit_ready}, 64'h1);

        // Early tail, then a clean packet.
        send(16'h0E80);
        send(16'h5234);
        exp_err_q.push_back(2'b10);
        send(16'h89AB);
        chk("early_tail_no_pkt", {63'h0, bus.pkt_valid}, 64'h0);
        exp_pkt_q.push_back(P2);
        send_p2();
        @(negedge clk);

        // Stray body and reserved type while idle.
        exp_err_q.push_back(2'b01);
        send(16'h5234);
        exp_err_q.push_back(2'b01);
        send(16'hC000);
        chk("stray_flit_ready", {63'h0, bus.flit_ready}, 64'h1);
        chk("stray_no_pkt", {63'h0, bus.pkt_valid}, 64'h0);

        // Reset in the middle of a packet.
        send(16'h0E80);
        send(16'h5234);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {bus.pkt_src, bus.pkt_des, bus.pkt_data}, 64'h0);
        chk("midrst_valid_err", {62'h0, bus.pkt_valid, bus.err}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pkt_q.push_back(P1);
        send_p1();
        @(negedge clk);

`ifdef DEPKT_ADDR_CHECK_EN
        // Packet for another node is swallowed through its tail.
        exp_err_q.push_back(2'b11);
        send(16'h0D40);
        send(16'h5234);
        send(16'h559E);
        send(16'h89AB);
        chk("addr_drop_no_pkt", {63'h0, bus.pkt_valid}, 64'h0);
        exp_pkt_q.push_back(P1);
        send_p1();
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("pkt_queue_empty", 64'(exp_pkt_q.size()), 64'h0);
        chk("err_queue_empty", 64'(exp_err_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
